i2s_sum_collector: RTL and testbench
====================================

// Module: i2s_sum_collector
// PURPOSE
//   Downstream stage of the serial I2S adder. Captures the adder's LSB-first serial
//   sum (one WIDTH-bit word per ws transition) and reassembles it into parallel words.
//   Completed words pass through a 2-entry output FIFO with a valid/ready handshake,
//   so a parallel consumer (register file, DAC framer) can absorb occasional stalls.
//   Runs entirely in the sck domain.
// PARAMETERS
//   WIDTH  24  bits per serial sum word (matches upstream adder word width)
//   SKIP   1   sck cycles ignored after a ws transition before bit 0 is sampled
// PORTS
//   sck        in   1      bit clock; all state updates on posedge sck
//   reset      in   1      asynchronous, active-low (0 = reset asserted)
//   ws         in   1      word select; every transition (either edge) starts a frame
//   sd         in   1      serial sum from adder, LSB first
//   out_ready  in   1      consumer accepts out_data when out_valid & out_ready
//   out_valid  out  1      FIFO head holds a word
//   out_data   out  WIDTH  FIFO head word
//   out_chan   out  1      ws level captured at frame start (0 = left, 1 = right)
//   overflow   out  1      sticky: a completed word was dropped because FIFO was full
//   short_frm  out  1      sticky: a frame was cut short by a ws transition
// BEHAVIOUR
//   Reset (async, reset=0): state=IDLE, ws_q=0, bit count=0, shift reg=0, FIFO empty,
//     out_valid=0, out_data=0, out_chan=0, overflow=0, short_frm=0. Release is synchronous to sck.
//   Frame start: on posedge with ws != ws_q (ws_q = ws registered each posedge).
//     Captures chan=ws, clears bit count and shift reg, enters SKIP (or SHIFT if SKIP=0).
//   FSM: IDLE -(frame start)-> SKIP -(SKIP cycles done)-> SHIFT -(WIDTH bits done)-> IDLE.
//     SKIP: counts SKIP posedges, samples nothing.
//     SHIFT: each posedge writes sd into shift reg bit [count], count++ (LSB first).
//     On the posedge sampling bit WIDTH-1: word+chan pushed into FIFO the same edge;
//     out_valid is high the next cycle if the FIFO was empty (latency 1 cycle after last bit).
//   Frame start while in SKIP or SHIFT: partial word discarded, short_frm set, new frame begins
//     same edge. Frame start on the same edge as the last bit: completed word pushed first,
//     then new frame begins; short_frm not set.
//   Extra sd bits after WIDTH bits (IDLE) are ignored.
//   FIFO: 2 entries, first-word fall-through. Pop when out_valid & out_ready.
//     Push when full and no pop that edge -> word dropped, overflow set, contents unchanged.
//     Push and pop on the same edge when full -> both happen, no overflow.
//     out_data/out_chan hold their value while out_valid=1 and out_ready=0.
//   overflow and short_frm clear only on reset.
//   Reset mid-frame: partial word and FIFO contents lost, no output glitch beyond reset values.
// STRUCTURE
//   Shared package/include: FSM state encoding (IDLE/SKIP/SHIFT), WIDTH default,
//     counter width = $clog2(WIDTH)+1.
//   Sub-module: sum_fifo2 (2-entry FWFT FIFO, data width WIDTH+1, full/empty, push/pop).
//   Top holds ws edge detect, FSM, bit counter, shift register, sticky flags.
// TESTING
//   1. ws 0->1, sd = 24'h00A5C3 LSB first after SKIP=1 -> out_valid 1 cycle after bit 23,
//      out_data=24'h00A5C3, out_chan=1.
//   2. Two frames (24'h000001 chan1, 24'hFFFFFF chan0), out_ready=0 -> both held in order;
//      third frame 24'h123456 -> dropped, overflow=1; then ready=1 drains 000001, FFFFFF.
//   3. ws toggles after 10 bits of a frame -> no word pushed from it, short_frm=1,
//      following full frame 24'h5A5A5A delivered intact.
//   4. FIFO full, out_ready=1 on the edge a new word completes -> no overflow, order preserved.
//   5. reset=0 asserted asynchronously mid-SHIFT with 1 word in FIFO -> out_valid=0, flags 0
//      immediately; after release, next frame 24'h800000 delivered correctly.
//   6. Co-simulation with upstream adder: sd1=24'h000010, sd2=24'h000020 -> out_data=24'h000030.

Source files
------------

// File: rtl/i2s_sum_collector_pkg.sv
// -----------------------------------------------------------------------------
// i2s_sum_collector_pkg
//   Shared definitions for the serial-sum collector: FSM state encoding,
//   default word width / skip count, and the bit-counter width helper.
// -----------------------------------------------------------------------------
package i2s_sum_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 24;
  localparam int SKIP_DEFAULT  = 1;

  // Counter must reach WIDTH-1 (and SKIP-1); one spare bit keeps headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sum_fifo2.sv
// -----------------------------------------------------------------------------
// sum_fifo2
//   Two-entry first-word-fall-through FIFO. The head entry is always visible on
//   o_data; o_empty low means o_data is valid.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_push       write i_data (ignored when full unless popping the same edge)
//     i_pop        remove the head entry (ignored when empty)
//     i_data       write data, DW bits
//     o_data       head entry
//     o_full       both entries occupied
//     o_empty      no entries
// -----------------------------------------------------------------------------
module sum_fifo2 #(
  parameter int DW = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == 2'd2);
  assign o_empty   = (r_cnt == 2'd0);
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, a write is only accepted if the head leaves on the same edge;
  // the freed slot is exactly the one r_wr points at.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_do_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sum_collector.sv
// -----------------------------------------------------------------------------
// i2s_sum_collector
//   Captures an LSB-first serial sum word (one per ws transition) and
//   reassembles it into parallel words delivered through a 2-entry FWFT FIFO
//   with a valid/ready output. Single clock domain (sck).
//   Ports:
//     sck        bit clock, all state on posedge
//     reset      asynchronous active-low reset
//     ws         word select; any transition starts a frame
//     sd         serial data, LSB first
//     out_ready  consumer ready
//     out_valid  FIFO head holds a word
//     out_data   FIFO head word
//     out_chan   ws level captured at that word's frame start
//     overflow   sticky: completed word dropped (FIFO full)
//     short_frm  sticky: frame cut short by a ws transition
//     dbg_state  current FSM state (ST_IDLE/ST_SKIP/ST_SHIFT encoding)
//   Handshake: a word transfers on a posedge where out_valid & out_ready are
//   both high; out_data/out_chan are stable while out_valid & ~out_ready.
// -----------------------------------------------------------------------------
module i2s_sum_collector
  import i2s_sum_collector_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SKIP  = SKIP_DEFAULT
) (
  input  logic             sck,
  input  logic             reset,
  input  logic             ws,
  input  logic             sd,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_chan,
  output logic             overflow,
  output logic             short_frm,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam int IW = $clog2(WIDTH);

  state_t           r_state;
  logic             r_ws_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_chan;
  logic             r_overflow;
  logic             r_short;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_chan_nxt;
  logic             w_start;
  logic             w_push;
  logic             w_short_set;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH:0]   w_fifo_dout;

  assign w_start = (ws != r_ws_q);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_chan_nxt  = r_chan;
    w_push      = 1'b0;
    w_short_set = 1'b0;
    // Shift register with the current sd bit merged at the counter position;
    // this is also the completed word on the last-bit edge.
    w_word                = r_shreg;
    w_word[r_cnt[IW-1:0]] = sd;

    case (r_state)
      ST_SKIP: begin
        if (r_cnt == CW'(SKIP - 1)) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shreg_nxt = w_word;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    // A frame start overrides the state update above. If it coincides with
    // the last bit, the completed word is still pushed and the frame is not
    // considered short.
    if (w_start) begin
      if (r_state != ST_IDLE && !w_push) begin
        w_short_set = 1'b1;
      end
      w_state_nxt = (SKIP == 0) ? ST_SHIFT : ST_SKIP;
      w_cnt_nxt   = '0;
      w_shreg_nxt = '0;
      w_chan_nxt  = ws;
    end
  end

  always_ff @(posedge sck or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ws_q     <= 1'b0;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_chan     <= 1'b0;
      r_overflow <= 1'b0;
      r_short    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ws_q  <= ws;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_chan  <= w_chan_nxt;
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_short_set) begin
        r_short <= 1'b1;
      end
    end
  end

  assign w_pop = ~w_empty & out_ready;

  sum_fifo2 #(
    .DW (WIDTH + 1)
  ) u_fifo (
    .clk     (sck),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_chan, w_word}),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = ~w_empty;
  assign out_data  = w_fifo_dout[WIDTH-1:0];
  assign out_chan  = w_fifo_dout[WIDTH];
  assign overflow  = r_overflow;
  assign short_frm = r_short;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_i2s_sum_collector.sv
module tb_i2s_sum_collector;

  localparam int W = 24;

  logic         sck;
  logic         reset;
  logic         ws;
  logic         sd;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_chan;
  logic         overflow;
  logic         short_frm;
  logic [1:0]   dbg_state;

  int total;
  int bad;
  logic [W:0] exp_q[$];

  i2s_sum_collector #(.WIDTH(W), .SKIP(1)) dut (
    .sck       (sck),
    .reset     (reset),
    .ws        (ws),
    .sd        (sd),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .overflow  (overflow),
    .short_frm (short_frm),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial sck = 1'b0;
  always #5 sck = ~sck;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: a word transfers on the posedge after a negedge where
  // out_valid & out_ready are seen high.
  always @(negedge sck) begin
    #1;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'({out_chan, out_data}), 32'h0);
      end else begin
        check("word", 32'({out_chan, out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    ws        = 1'b0;
    sd        = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge sck);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_chan",  32'(out_chan),  32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);
    check("rst_short", 32'(short_frm), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    reset = 1'b1;
    @(negedge sck);
  endtask

  // Frame start on the posedge after ws toggles, one skipped posedge, then
  // W data bits. With do_toggle=0 the frame start already happened on the
  // previous frame's last-bit edge.
  task automatic send_frame(input logic [W-1:0] word, input bit do_toggle, input bit kept,
                            input bit toggle_last, input bit ready_last, input bit check_lat);
    logic chan;
    if (do_toggle) begin
      ws = ~ws;
      @(negedge sck);
    end
    chan = ws;
    @(negedge sck);
    for (int i = 0; i < W; i++) begin
      sd = word[i];
      if (i == W - 1) begin
        if (kept) exp_q.push_back({chan, word});
        if (toggle_last) ws = ~ws;
        if (ready_last) out_ready = 1'b1;
        if (check_lat) check("lat_before", 32'(out_valid), 32'h0);
      end
      @(negedge sck);
    end
    if (check_lat) check("lat_after", 32'(out_valid), 32'h1);
  endtask

  task automatic send_partial(input int nbits);
    ws = ~ws;
    @(negedge sck);
    @(negedge sck);
    for (int i = 0; i < nbits; i++) begin
      sd = 1'($urandom_range(0, 1));
      @(negedge sck);
    end
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge sck);
      #2;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    do_reset();

    // 1: single word, latency and channel
    out_ready = 1'b1;
    send_frame(24'h00A5C3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t1_data", 32'(out_data), 32'h00A5C3);
    check("t1_chan", 32'(out_chan), 32'h1);
    wait_drain("t1_drain", 10);

    // 2: fill with consumer stalled, third word dropped
    do_reset();
    send_frame(24'h000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_hold_data", 32'(out_data), 32'h000001);
    check("t2_ovf_before", 32'(overflow), 32'h0);
    send_frame(24'h123456, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_ovf", 32'(overflow), 32'h1);
    check("t2_hold_data2", 32'(out_data), 32'h000001);
    check("t2_hold_chan", 32'(out_chan), 32'h1);
    out_ready = 1'b1;
    wait_drain("t2_drain", 10);
    repeat (2) @(negedge sck);
    check("t2_empty", 32'(out_valid), 32'h0);

    // 3: ws toggles mid-frame
    check("t3_short_before", 32'(short_frm), 32'h0);
    send_partial(10);
    send_frame(24'h5A5A5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_short", 32'(short_frm), 32'h1);
    wait_drain("t3_drain", 10);

    // 4: full FIFO, pop on the same edge a word completes
    do_reset();
    send_frame(24'h111111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(24'h222222, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(24'h333333, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain("t4_drain", 10);
    check("t4_ovf", 32'(overflow), 32'h0);

    // 5: asynchronous reset mid-frame with one word queued
    do_reset();
    send_frame(24'h0ABCDE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_partial(10);
    send_partial(5);
    check("t5_short_pre", 32'(short_frm), 32'h1);
    check("t5_valid_pre", 32'(out_valid), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check("t5_valid_rst", 32'(out_valid), 32'h0);
    check("t5_short_rst", 32'(short_frm), 32'h0);
    check("t5_ovf_rst", 32'(overflow), 32'h0);
    exp_q.delete();
    ws = 1'b0;
    @(negedge sck);
    @(negedge sck);
    reset = 1'b1;
    @(negedge sck);
    out_ready = 1'b1;
    send_frame(24'h800000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_drain("t5_drain", 10);

    // 6: adder sum, back-to-back frame starting on the last-bit edge,
    //    random words, then trailing sd bits in idle
    send_frame(24'h000010 + 24'h000020, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(24'hC0FFEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_short", 32'(short_frm), 32'h0);
    for (int k = 0; k < 4; k++) begin
      send_frame(W'($urandom_range(0, 32'hFFFFFF)), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      sd = 1'($urandom_range(0, 1));
      @(negedge sck);
    end
    wait_drain("t6_drain", 10);
    repeat (3) @(negedge sck);
    check("t6_idle_valid", 32'(out_valid), 32'h0);
    check("t6_ovf", 32'(overflow), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
